// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS common-cathode
// 7-segment digits sharing one external hex decoder.
// - Double-buffered display value (shadow -> active) loaded through valid/ready;
//   the shadow value is promoted only on a frame boundary or while idle.
// - Each digit slot lasts TICK_DIV cycles; the first BLANK_CYCLES cycles keep
//   all digits dark so the decoder can settle on the next nibble (anti-ghosting).
// Optional build macro: LEADING_ZERO_BLANK_EN -- when defined, leading zero
// digits (index >= 1) stay dark; digit 0 is always shown.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int TICK_DIV     = 1000,
   parameter int BLANK_CYCLES = 50
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [NUM_DIGITS*4-1:0] load_value,
   output logic [3:0]              dec_nibble,
   input  logic [6:0]              seg_in,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done
);

   localparam int CW = $clog2(TICK_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int DW = NUM_DIGITS * 4;

   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   // A slot starts blanked unless there are no blank cycles at all.
   localparam state_t SLOT_FIRST_ST = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

   state_t                state_r, state_nxt_s;
   logic [CW-1:0]         cnt_r, cnt_nxt_s;
   logic [IW-1:0]         idx_r, idx_nxt_s;
   logic                  frame_end_s;

   logic [DW-1:0]         active_r, active_nxt_s;
   logic [DW-1:0]         shadow_r, shadow_nxt_s;
   logic                  pending_r, pending_nxt_s;

   logic [NUM_DIGITS-1:0] lit_s;
   logic                  show_r, show_nxt_s;
   logic [NUM_DIGITS-1:0] digit_en_r, digit_en_nxt_s;
   logic [3:0]            nibble_r, nibble_nxt_s;
   logic                  frame_done_r;

   // State register of the scan FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: slot counter, digit index and frame-end detection.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      idx_nxt_s   = idx_r;
      frame_end_s = 1'b0;
      if (!enable) begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = {CW{1'b0}};
         idx_nxt_s   = {IW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nxt_s = SLOT_FIRST_ST;
               cnt_nxt_s   = {CW{1'b0}};
               idx_nxt_s   = {IW{1'b0}};
            end
            ST_BLANK, ST_SHOW: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_nxt_s   = {CW{1'b0}};
                  state_nxt_s = SLOT_FIRST_ST;
                  if (idx_r == IDX_LAST) begin
                     idx_nxt_s   = {IW{1'b0}};
                     frame_end_s = 1'b1;
                  end else begin
                     idx_nxt_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
                  end
               end else begin
                  cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                  if ((int'(cnt_r) + 1) >= BLANK_CYCLES) begin
                     state_nxt_s = ST_SHOW;
                  end else begin
                     state_nxt_s = ST_BLANK;
                  end
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = {CW{1'b0}};
               idx_nxt_s   = {IW{1'b0}};
            end
         endcase
      end
   end

   // Double buffer: promote shadow at a frame end or while idle, else accept a new load.
   // Promotion needs pending=1 and capture needs pending=0, so they never collide.
   always_comb begin
      active_nxt_s  = active_r;
      shadow_nxt_s  = shadow_r;
      pending_nxt_s = pending_r;
      if (pending_r && (frame_end_s || (state_r == ST_IDLE))) begin
         active_nxt_s  = shadow_r;
         pending_nxt_s = 1'b0;
      end else if (load_valid && !pending_r) begin
         shadow_nxt_s  = load_value;
         pending_nxt_s = 1'b1;
      end else begin
         pending_nxt_s = pending_r;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Digit visibility: a digit is dark when it and all higher digits are zero.
   always_comb begin
      logic nz_v;
      nz_v  = 1'b0;
      lit_s = {NUM_DIGITS{1'b0}};
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nz_v     = nz_v | (active_nxt_s[4*i +: 4] != 4'h0);
         lit_s[i] = (i == 0) ? 1'b1 : nz_v;
      end
   end
`else
   // Digit visibility: every digit is displayed.
   always_comb begin
      lit_s = {NUM_DIGITS{1'b1}};
   end
`endif

   // Output logic: next values of the registered digit select, show flag and nibble.
   always_comb begin
      show_nxt_s     = 1'b0;
      digit_en_nxt_s = {NUM_DIGITS{1'b0}};
      nibble_nxt_s   = active_nxt_s[{idx_nxt_s, 2'b00} +: 4];
      if ((state_nxt_s == ST_SHOW) && lit_s[idx_nxt_s]) begin
         show_nxt_s     = 1'b1;
         digit_en_nxt_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nxt_s;
      end else begin
         show_nxt_s     = 1'b0;
         digit_en_nxt_s = {NUM_DIGITS{1'b0}};
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r        <= {CW{1'b0}};
         idx_r        <= {IW{1'b0}};
         active_r     <= {DW{1'b0}};
         shadow_r     <= {DW{1'b0}};
         pending_r    <= 1'b0;
         show_r       <= 1'b0;
         digit_en_r   <= {NUM_DIGITS{1'b0}};
         nibble_r     <= 4'h0;
         frame_done_r <= 1'b0;
      end else begin
         cnt_r        <= cnt_nxt_s;
         idx_r        <= idx_nxt_s;
         active_r     <= active_nxt_s;
         shadow_r     <= shadow_nxt_s;
         pending_r    <= pending_nxt_s;
         show_r       <= show_nxt_s;
         digit_en_r   <= digit_en_nxt_s;
         nibble_r     <= nibble_nxt_s;
         frame_done_r <= frame_end_s;
      end
   end

   // Segments pass through only while the current digit is being shown.
   assign seg_out    = seg_in & {7{show_r}};
   assign digit_en   = digit_en_r;
   assign dec_nibble = nibble_r;
   assign frame_done = frame_done_r;
   assign load_ready = ~pending_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2).
// A position-in-frame model predicts every output each cycle; directed
// literal checks pin the model at key points of each scenario.
module tb_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int TICK  = 8;
   localparam int BLANK = 2;
   localparam int FRAME = ND * TICK;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic [15:0]   load_value = 16'h0000;
   logic [3:0]    dec_nibble;
   logic [6:0]    seg_in;
   logic [6:0]    seg_out;
   logic [ND-1:0] digit_en;
   logic          frame_done;

   int errs   = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   // model state
   bit          m_run;
   int          m_pos;
   logic [15:0] m_active, m_shadow;
   bit          m_pending, m_fd;

   seg_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TICK), .BLANK_CYCLES(BLANK)) dut (
      .clk(clk), .rst(rst), .enable(enable), .load_valid(load_valid),
      .load_ready(load_ready), .load_value(load_value), .dec_nibble(dec_nibble),
      .seg_in(seg_in), .seg_out(seg_out), .digit_en(digit_en), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
         4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
         4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
         4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
      endcase
   endfunction

   // external decoder stand-in
   assign seg_in = seg_of(dec_nibble);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // model: position within the frame since scanning started
   always @(posedge clk) begin
      bit wrap, copy;
      if (rst) begin
         m_run = 1'b0; m_pos = 0; m_active = 16'h0; m_shadow = 16'h0;
         m_pending = 1'b0; m_fd = 1'b0;
      end else begin
         wrap = m_run && enable && (m_pos == FRAME - 1);
         copy = m_pending && (wrap || !m_run);
         if (copy) begin
            m_active = m_shadow; m_pending = 1'b0;
         end else if (load_valid && !m_pending) begin
            m_shadow = load_value; m_pending = 1'b1;
         end
         m_fd = wrap;
         if (!enable) begin
            m_run = 1'b0; m_pos = 0;
         end else if (!m_run) begin
            m_run = 1'b1; m_pos = 0;
         end else begin
            m_pos = (m_pos + 1) % FRAME;
         end
      end
   end

   // compare every cycle against the model
   always @(negedge clk) begin
      int slot, off;
      bit show;
      logic [3:0] nib;
      logic [ND-1:0] en;
      if (chk_on) begin
         slot = m_pos / TICK;
         off  = m_pos % TICK;
         nib  = 4'((m_active >> (4 * slot)) & 16'h000F);
         show = m_run && (off >= BLANK) &&
                (!LZ || slot == 0 || ((m_active >> (4 * slot)) != 16'h0));
         en   = show ? (4'b0001 << slot) : 4'b0000;
         check("cmp_digit_en", 32'(digit_en), 32'(en));
         check("cmp_seg_out", 32'(seg_out), show ? 32'(seg_of(nib)) : 32'h0);
         check("cmp_dec_nibble", 32'(dec_nibble), 32'(nib));
         check("cmp_frame_done", 32'(frame_done), 32'(m_fd));
         check("cmp_load_ready", 32'(load_ready), 32'(!m_pending));
      end
   end

   initial begin
      // reset
      cyc(1);
      chk_on = 1'b1;
      cyc(2);
      check("rst_digit_en", 32'(digit_en), 32'h0);
      check("rst_seg_out", 32'(seg_out), 32'h0);
      check("rst_dec_nibble", 32'(dec_nibble), 32'h0);
      check("rst_frame_done", 32'(frame_done), 32'h0);
      check("rst_load_ready", 32'(load_ready), 32'h1);

      // 1: basic scan with active = 0
      rst = 1'b0; enable = 1'b1;
      cyc(1);  check("s1_blank0", 32'(digit_en), 32'h0);
      cyc(2);  check("s1_d0", 32'(digit_en), 32'b0001);
      cyc(8);  check("s1_d1", 32'(digit_en), 32'b0010);
      cyc(8);  check("s1_d2", 32'(digit_en), 32'b0100);
      cyc(8);  check("s1_d3", 32'(digit_en), 32'b1000);
      cyc(6);  check("s1_fd", 32'(frame_done), 32'h1);
               check("s1_wrap_blank", 32'(digit_en), 32'h0);
      cyc(1);  check("s1_fd_low", 32'(frame_done), 32'h0);

      // 2: mid-frame load of 1A3F
      cyc(15);
      load_value = 16'h1A3F; load_valid = 1'b1;
      cyc(1);  load_valid = 1'b0;
      check("s2_ready_low", 32'(load_ready), 32'h0);
      check("s2_old_nib", 32'(dec_nibble), 32'h0);
      cyc(15); check("s2_nib0", 32'(dec_nibble), 32'hF);
               check("s2_ready_back", 32'(load_ready), 32'h1);
               check("s2_fd", 32'(frame_done), 32'h1);
      cyc(8);  check("s2_nib1", 32'(dec_nibble), 32'h3);
      cyc(8);  check("s2_nib2", 32'(dec_nibble), 32'hA);
      cyc(8);  check("s2_nib3", 32'(dec_nibble), 32'h1);

      // 3: second load while pending is ignored; load at the wrap waits a frame
      load_value = 16'h2222; load_valid = 1'b1;
      cyc(1);  load_value = 16'h3333;
      cyc(1);  load_valid = 1'b0;
      cyc(6);  check("s3_first_kept", 32'(dec_nibble), 32'h2);
      cyc(31);
      load_value = 16'h4567; load_valid = 1'b1;
      cyc(1);  load_valid = 1'b0;
      check("s3_wrap_old", 32'(dec_nibble), 32'h2);
      check("s3_wrap_pending", 32'(load_ready), 32'h0);
      cyc(32); check("s3_next_frame", 32'(dec_nibble), 32'h7);
               check("s3_ready", 32'(load_ready), 32'h1);

      // 4: disable during digit 2 show, then re-enable
      cyc(20); check("s4_d2_show", 32'(digit_en), 32'b0100);
      enable = 1'b0;
      cyc(1);  check("s4_off_en", 32'(digit_en), 32'h0);
               check("s4_off_seg", 32'(seg_out), 32'h0);
               check("s4_off_nib", 32'(dec_nibble), 32'h7);
      cyc(3);
      enable = 1'b1;
      cyc(1);  check("s4_restart_blank", 32'(digit_en), 32'h0);
      cyc(2);  check("s4_restart_d0", 32'(digit_en), 32'b0001);
               check("s4_restart_seg", 32'(seg_out), 32'(seg_of(4'h7)));

      // 5: reset mid-show with a pending value
      load_value = 16'h9999; load_valid = 1'b1;
      cyc(1);  load_valid = 1'b0;
      check("s5_pending", 32'(load_ready), 32'h0);
      cyc(3);
      rst = 1'b1;
      cyc(1);  check("s5_rst_en", 32'(digit_en), 32'h0);
               check("s5_rst_seg", 32'(seg_out), 32'h0);
               check("s5_rst_nib", 32'(dec_nibble), 32'h0);
               check("s5_rst_fd", 32'(frame_done), 32'h0);
               check("s5_rst_ready", 32'(load_ready), 32'h1);
      rst = 1'b0; enable = 1'b0;
      cyc(2);  check("s5_cleared", 32'(dec_nibble), 32'h0);

      // 6: idle load of 0050 then scan (leading-zero behaviour if enabled)
      load_value = 16'h0050; load_valid = 1'b1;
      cyc(1);  load_valid = 1'b0;
      cyc(1);  check("s6_idle_copy", 32'(load_ready), 32'h1);
      enable = 1'b1;
      cyc(1);
      cyc(3);  check("s6_d0", 32'(digit_en), 32'b0001);
      cyc(8);  check("s6_d1", 32'(digit_en), 32'b0010);
               check("s6_d1_seg", 32'(seg_out), 32'(seg_of(4'h5)));
      cyc(8);  check("s6_d2", 32'(digit_en), LZ ? 32'h0 : 32'b0100);
      cyc(8);  check("s6_d3", 32'(digit_en), LZ ? 32'h0 : 32'b1000);
      cyc(5);
      enable = 1'b0;
      cyc(1);
      load_value = 16'h0000; load_valid = 1'b1;
      cyc(1);  load_valid = 1'b0;
      cyc(1);
      enable = 1'b1;
      cyc(1);
      cyc(3);  check("s6z_d0", 32'(digit_en), 32'b0001);
      cyc(8);  check("s6z_d1", 32'(digit_en), LZ ? 32'h0 : 32'b0010);
      cyc(21);
      enable = 1'b0;
      cyc(2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one 4-bit-to-7-segment decoder across NUM_DIGITS common-cathode digits. It holds a double-buffered hex value, presents one nibble at a time to the external decoder, and gates the decoder's segment output. It drives a one-hot digit enable, inserts an anti-ghosting blank interval between digits, and accepts new display values through a valid/ready handshake. New values take effect only on frame boundaries, so no frame ever shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8).
TICK_DIV, 1000, clock cycles per digit slot (>= 2).
BLANK_CYCLES, 50, cycles at the start of each slot with all digits off (0 <= BLANK_CYCLES < TICK_DIV).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
enable  input  1  scan enable; low forces IDLE
load_valid  input  1  load_value is valid
load_ready  output  1  shadow buffer can accept a value
load_value  input  NUM_DIGITS*4  new display value; digit i = bits [4i+3:4i]
dec_nibble  output  4  nibble presented to the external decoder
seg_in  input  7  decoder output, bit0..6 = a..g, active-high
seg_out  output  7  gated segments to the pads
digit_en  output  NUM_DIGITS  one-hot, active-high digit select
frame_done  output  1  one-cycle pulse after the last digit slot

Behaviour:
- Decided: one clock, clk; reset rst is synchronous and active-high; all state updates on the rising clk edge.
- Reset values:
  - state = IDLE, digit index = 0, slot counter = 0.
  - Active and shadow registers = 0, pending = 0.
  - digit_en = 0, seg_out = 0, dec_nibble = 0, frame_done = 0, load_ready = 1.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - digit_en = 0 and seg_out = 0.
  - When enable = 1, go to BLANK with digit index 0 and counter 0. If BLANK_CYCLES = 0, go directly to SHOW.
- Slot timing: each slot lasts exactly TICK_DIV cycles; the counter runs 0..TICK_DIV-1.
  - BLANK: counter < BLANK_CYCLES. digit_en = 0, seg_out = 0, dec_nibble = current digit's nibble (gives the decoder time to settle).
  - SHOW: the rest of the slot. digit_en has the bit for the current index set (registered). seg_out = seg_in AND'd with the show flag (combinational gate only).
- End of slot (counter = TICK_DIV-1):
  - Counter returns to 0.
  - If index < NUM_DIGITS-1: index increments.
  - Else: index wraps to 0, frame_done pulses on the next cycle, and if pending = 1 the shadow register copies to active and pending clears.
  - Next state is BLANK (or SHOW when BLANK_CYCLES = 0).
- dec_nibble is registered and always reflects active[4*idx+3:4*idx]. It updates on the same edge as index and as any active-register copy.
- Handshake:
  - load_ready = ~pending.
  - On load_valid & load_ready, load_value goes into the shadow register and pending is set.
  - While pending = 1, load_value is ignored.
  - In IDLE, a pending shadow copies to active on the next cycle.
- Simultaneous capture and frame end: the captured value stays pending and transfers at the following frame end.
- enable falling in any state: next cycle go to IDLE, index = 0, counter = 0, outputs blanked. Active, shadow and pending are retained.
- rst asserted mid-operation overrides everything on that edge.
- The counter width is the minimum needed for TICK_DIV-1. The counter never exceeds TICK_DIV-1.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: in SHOW, digit i (i >= 1) has seg_out forced to 0 and digit_en[i] forced to 0 if its nibble and every higher-index nibble of active are 4'h0. Digit 0 is always shown, so a value of 0 displays a single "0". Slot timing is unchanged.
- Undefined: all digits are displayed normally.

Test Plan:
All scenarios use NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
1. Reset, then enable=1 with active=0 -> digit_en follows 0001, 0010, 0100, 1000 in 8-cycle slots, each with 2 leading cycles of 0000. frame_done pulses every 32 cycles.
2. load_value=16'h1A3F with load_valid held for 1 cycle at mid-frame -> load_ready drops to 0. dec_nibble stays on the old value until the frame end, then shows F, 3, A, 1 in digit 0..3 slots. load_ready returns to 1 at the wrap.
3. Second load_valid while pending -> value ignored, and the first value is displayed. A load accepted in the same cycle as the frame-end wrap displays only after the next frame end.
4. enable deasserted during digit 2 SHOW -> next cycle digit_en=0 and seg_out=0. Re-enable -> scanning restarts at digit 0 BLANK with the retained value.
5. rst pulsed mid-SHOW with pending=1 -> all outputs and registers return to their reset values, and load_ready=1.
6. With LEADING_ZERO_BLANK_EN defined, active=16'h0050 -> digits 2 and 3 are dark, digits 0 and 1 are lit. With active=16'h0000 -> only digit 0 is lit.
